// File: rtl/aes_pkg.sv
// AES-128 shared types, round-function helpers and FSM encoding.
// Used by aes_sbox and aes_iter_core.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } aes_state_e;

  typedef struct packed {
    logic [127:0] st;
    logic [127:0] rk;
  } aes_ctx_t;

  localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      if (r == 4'(i)) v = RCON_TBL[87-8*i -: 8];
    end
    return v;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // inverse is a^254, built from the squares a^2 .. a^128
  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] v;
    sq = gmul(a, a);
    v  = sq;
    for (int i = 0; i < 6; i++) begin
      sq = gmul(sq, sq);
      v  = gmul(v, sq);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]}
             ^ 8'h63;
  endfunction

  function automatic logic [127:0] shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(
    input logic [127:0] s
  );
    return {mix_col(s[127:96]), mix_col(s[95:64]),
            mix_col(s[63:32]),  mix_col(s[31:0])};
  endfunction

  // sw is SubWord(RotWord(w3)) of the previous key
  function automatic logic [127:0] key_step(
    input logic [127:0] k,
    input logic [31:0]  sw,
    input logic [7:0]   rc
  );
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sw ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, combinational.
// SBOX_IMPL: 0 = lookup table, 1 = field inversion plus affine map.
module aes_sbox import aes_pkg::*; #(
  parameter int SBOX_IMPL = 0
) (
  input  logic [7:0] a,
  output logic [7:0] y
);

  if (SBOX_IMPL == 1) begin : g_calc
    assign y = sbox_calc(a);
  end else begin : g_tbl
    logic [127:0] row;
    always_comb begin
      row = '0;
      unique case (a[7:4])
        4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
        4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
        4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
        4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
        4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
        4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
        4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
        4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
        4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
        4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
        4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
        4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
        4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
        4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
        4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
        4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
      endcase
    end
    // column n of the row starts at bit 127-8n
    assign y = row[{~a[3:0], 3'b111} -: 8];
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryptor, ROUNDS_PER_CYCLE rounds per clock.
// `define AES_CBC_CHAIN_EN to xor the last ciphertext into chained blocks.
module aes_iter_core import aes_pkg::*; #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int SBOX_IMPL        = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  input  logic         chain
);

  localparam int R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 5 || R == 10)) begin : g_bad
    $error("aes_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  aes_state_e   state;
  aes_state_e   state_n;
  aes_ctx_t     cur;
  aes_ctx_t     nxt;
  logic [3:0]   rnd;
  logic [127:0] ct_q;
  logic [127:0] load_st;
  logic         accept;
  logic         done;
  logic         out_hs;

  assign in_ready   = (state != RUN) && (state != HOLD);
  assign busy       = (state == RUN);
  assign out_valid  = (state == HOLD);
  assign ciphertext = ct_q;
  assign accept     = in_valid & in_ready;
  assign out_hs     = out_valid & out_ready;
  // last round handled this cycle is rnd+R-1
  assign done       = (5'(rnd) + 5'(R)) > 5'd10;

`ifdef AES_CBC_CHAIN_EN
  logic [127:0] prev_ct;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_ct <= '0;
    end else if (out_hs) begin
      prev_ct <= ct_q;
    end
  end

  assign load_st = plaintext ^ key ^ (chain ? prev_ct : 128'h0);
`else
  logic unused_chain;
  assign unused_chain = chain;
  assign load_st      = plaintext ^ key;
`endif

  for (genvar j = 0; j < R; j++) begin : g_rnd
    aes_ctx_t     i_c;
    aes_ctx_t     o_c;
    logic [3:0]   ri;
    logic [31:0]  rot;
    logic [31:0]  ksb;
    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] nk;
    logic [127:0] ns;

    if (j == 0) begin : g_src
      assign i_c = cur;
    end else begin : g_src
      assign i_c = g_rnd[j-1].o_c;
    end

    assign ri  = rnd + 4'(j);
    assign rot = {i_c.rk[23:0], i_c.rk[31:24]};

    for (genvar b = 0; b < 16; b++) begin : g_sb
      aes_sbox #(.SBOX_IMPL(SBOX_IMPL)) u_sb (
        .a(i_c.st[127-8*b -: 8]),
        .y(sb[127-8*b -: 8])
      );
    end

    for (genvar b = 0; b < 4; b++) begin : g_kb
      aes_sbox #(.SBOX_IMPL(SBOX_IMPL)) u_kb (
        .a(rot[31-8*b -: 8]),
        .y(ksb[31-8*b -: 8])
      );
    end

    assign nk  = key_step(i_c.rk, ksb, rcon(ri));
    assign sr  = shift_rows(sb);
    assign ns  = ((ri == 4'd10) ? sr : mix_columns(sr)) ^ nk;
    assign o_c = '{st: ns, rk: nk};
  end

  assign nxt = g_rnd[R-1].o_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      RUN:     if (done) state_n = HOLD;
      HOLD:    if (out_ready) state_n = IDLE;
      default: state_n = in_valid ? RUN : IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur  <= '0;
      rnd  <= '0;
      ct_q <= '0;
    end else if (accept) begin
      cur  <= '{st: load_st, rk: key};
      rnd  <= 4'd1;
    end else if (busy) begin
      cur  <= nxt;
      rnd  <= done ? 4'd0 : rnd + 4'(R);
      if (done) ct_q <= nxt.st;
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench: four cores (1/2/5/10 rounds per clock) on shared inputs.
// FIPS-197 vectors, latency, backpressure, abort by reset, input toggling.
module tb_aes_iter_core;

  logic         clk       = 1'b0;
  logic         reset     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic         chain     = 1'b0;
  logic [127:0] plaintext = '0;
  logic [127:0] key       = '0;
  logic [3:0]   ir;
  logic [3:0]   ov;
  logic [3:0]   bz;
  logic [127:0] ct [4];
  int           n_chk = 0;
  int           n_err = 0;

  localparam int RPC [4] = '{1, 2, 5, 10};

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C2 = 128'h69d5c2eb2e2e624750541d3bbc692ba5;

  always #5 clk = ~clk;

  for (genvar d = 0; d < 4; d++) begin : g_dut
    aes_iter_core #(
      .ROUNDS_PER_CYCLE(RPC[d]),
      .SBOX_IMPL(d % 2)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(ir[d]),
      .plaintext(plaintext),
      .key(key),
      .out_valid(ov[d]),
      .out_ready(out_ready),
      .ciphertext(ct[d]),
      .busy(bz[d]),
      .chain(chain)
    );
  end

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic start_block(
    input logic [127:0] p,
    input logic [127:0] k,
    input logic         ch,
    input logic [127:0] exp,
    input bit           tog,
    input string        tag
  );
    int lat [4];
    for (int d = 0; d < 4; d++) lat[d] = 0;
    check({tag, "_rdy"}, 128'(ir), 128'hf);
    plaintext = p;
    key       = k;
    chain     = ch;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "_run"}, 128'({bz, ir}), 128'hf0);
    for (int c = 1; c <= 12; c++) begin
      if (tog) begin
        plaintext = ~plaintext;
        key       = {key[126:0], ~key[127]};
      end
      @(posedge clk);
      #1;
      if (c == 1) check({tag, "_busy1"}, 128'(bz), 128'h7);
      for (int d = 0; d < 4; d++) begin
        if (ov[d] && lat[d] == 0) lat[d] = c;
      end
    end
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_lat%0d", tag, RPC[d]),
            128'(lat[d]), 128'(10 / RPC[d]));
      check($sformatf("%s_ct%0d", tag, RPC[d]), ct[d], exp);
    end
    chain = 1'b0;
  endtask

  task automatic release_block(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_rel"}, 128'({ov, ir}), 128'h0f);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           bad;
    logic [127:0] hold [4];

    #2;
    check("rst_out", 128'({ir, ov, bz}), 128'hf00);
    check("rst_ct1", ct[0], 128'h0);
    check("rst_ct10", ct[3], 128'h0);
    #10 reset = 1'b1;
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_ordy", 128'({ir, ov, bz}), 128'hf00);

    start_block(PT_B, KEY_B, 1'b0, CT_B, 1'b0, "fipsB");
    release_block("fipsB");
    start_block(PT_C, KEY_C, 1'b0, CT_C, 1'b0, "c1");
    release_block("c1");

    start_block(PT_C, KEY_C, 1'b0, CT_C, 1'b0, "bp");
    for (int d = 0; d < 4; d++) hold[d] = ct[d];
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (ov != 4'hf || ir != 4'h0) bad++;
      for (int d = 0; d < 4; d++) begin
        if (ct[d] !== hold[d]) bad++;
      end
    end
    check("bp_stable", 128'(bad), 128'h0);
    release_block("bp");

    plaintext = PT_C;
    key       = KEY_C;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_run", 128'({bz[0], ov[0]}), 128'h2);
    reset = 1'b0;
    #1;
    check("abort_out", 128'({ir, ov, bz}), 128'hf00);
    check("abort_ct", ct[0], 128'h0);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    start_block(PT_C, KEY_C, 1'b0, CT_C, 1'b0, "post_rst");
    release_block("post_rst");

    start_block(PT_B, KEY_B, 1'b0, CT_B, 1'b1, "toggle");
    release_block("toggle");

`ifdef AES_CBC_CHAIN_EN
    start_block(PT_C, KEY_C, 1'b0, CT_C, 1'b0, "cbc1");
    release_block("cbc1");
    start_block(PT_C2, KEY_C, 1'b1, CT_C, 1'b0, "cbc2");
    release_block("cbc2");
`else
    start_block(PT_C, KEY_C, 1'b1, CT_C, 1'b0, "chain_ign");
    release_block("chain_ign");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
